// File: rtl/prefetch_pkg.sv
// ---------------------------------------------------------------------------
// prefetch_pkg
// Shared definitions for the instruction prefetch unit:
//   state_t        fetch FSM states (IDLE, REQ, DISCARD)
//   DEFAULT_DEPTH  default FIFO depth
//   PTR_W / CNT_W  pointer and occupancy widths for the default depth
//   ptr_width()    pointer width for an arbitrary power-of-two depth
// ---------------------------------------------------------------------------
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH = 4;
  localparam int PTR_W         = $clog2(DEFAULT_DEPTH);
  localparam int CNT_W         = PTR_W + 1;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// ---------------------------------------------------------------------------
// prefetch_fifo
// Synchronous FIFO holding {instruction, pc} pairs with a registered head.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   clear             empties the FIFO; wins over push and pop
//   push, push_instr, push_pc   write one entry
//   pop               remove the head entry
//   head_valid, head_instr, head_pc   registered head of the FIFO
//   count             current occupancy (0..DEPTH)
// ---------------------------------------------------------------------------
module prefetch_fifo
  import prefetch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  logic [DATA_W-1:0]       push_instr,
  input  logic [ADDR_W-1:0]       push_pc,
  input  logic                    pop,
  output logic                    head_valid,
  output logic [DATA_W-1:0]       head_instr,
  output logic [ADDR_W-1:0]       head_pc,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_W + ADDR_W;

  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          pop_eff, push_eff, bypass;
  logic [EW-1:0] head_next;

  always_comb begin
    pop_eff     = pop && (count_reg != '0);
    push_eff    = push && ((count_reg != CW'(DEPTH)) || pop_eff);
    rd_ptr_next = rd_ptr_reg + PW'(pop_eff);
    wr_ptr_next = wr_ptr_reg + PW'(push_eff);
    count_next  = count_reg + CW'(push_eff) - CW'(pop_eff);
    // The head register is loaded from the slot that becomes the head after
    // this edge; when that slot is being written right now, forward the
    // incoming data so an empty FIFO shows a push after one cycle.
    bypass      = push_eff && (wr_ptr_reg == rd_ptr_next);
    head_next   = bypass ? {push_instr, push_pc} : mem[rd_ptr_next];
  end

  // Storage array, no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (push_eff && !clear) begin
      mem[wr_ptr_reg] <= {push_instr, push_pc};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_valid <= 1'b0;
      head_instr <= '0;
      head_pc    <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      head_valid <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      head_valid <= (count_next != '0);
      if (count_next != '0) begin
        {head_instr, head_pc} <= head_next;
      end
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/instr_prefetch_unit.sv
// ---------------------------------------------------------------------------
// instr_prefetch_unit
// Fetches instruction words over a req/ack memory handshake, buffers them
// with their PC in prefetch_fifo and presents the head to the fetch stage.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   redirect, redirect_pc flush buffer and restart fetching at redirect_pc
//   hold                  consumer stall; head is not consumed while 1
//   instr_valid, instr, instr_pc   registered head entry
//   mem_req, mem_addr     registered fetch request (one outstanding max)
//   mem_ack, mem_data     memory response, data valid with ack
//   count                 FIFO occupancy
// ---------------------------------------------------------------------------
module instr_prefetch_unit
  import prefetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect,
  input  logic [ADDR_W-1:0]       redirect_pc,
  input  logic                    hold,
  output logic                    instr_valid,
  output logic [DATA_W-1:0]       instr,
  output logic [ADDR_W-1:0]       instr_pc,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int CW = ptr_width(DEPTH) + 1;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic              mem_req_reg, mem_req_next;
  logic [ADDR_W-1:0] fetch_pc_inc, target_pc;
  logic              push, pop, space_after;
  logic [CW-1:0]     occ_after;

  prefetch_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (redirect),
    .push       (push),
    .push_instr (mem_data),
    .push_pc    (mem_addr_reg),
    .pop        (pop),
    .head_valid (instr_valid),
    .head_instr (instr),
    .head_pc    (instr_pc),
    .count      (count)
  );

  always_comb begin
    // Redirect outranks the consumer and the memory: nothing is popped or
    // pushed in a redirect cycle, the FIFO is simply cleared.
    pop          = instr_valid && !hold && !redirect;
    push         = (state_reg == REQ) && mem_ack && !redirect;
    occ_after    = CW'(count) + CW'(push) - CW'(pop);
    space_after  = (occ_after < CW'(DEPTH));
    fetch_pc_inc = fetch_pc_reg + ADDR_W'(1);
    target_pc    = redirect ? redirect_pc : fetch_pc_reg;

    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    mem_req_next  = mem_req_reg;
    mem_addr_next = mem_addr_reg;

    if (redirect) begin
      fetch_pc_next = redirect_pc;
    end

    case (state_reg)
      IDLE: begin
        // After a redirect the FIFO is empty, so space is guaranteed.
        if (redirect || space_after) begin
          state_next    = REQ;
          mem_req_next  = 1'b1;
          mem_addr_next = target_pc;
        end
      end
      REQ: begin
        if (redirect) begin
          if (mem_ack) begin
            state_next    = REQ;
            mem_addr_next = redirect_pc;
          end else begin
            // Request still in flight: keep it up until it completes and
            // throw its data away.
            state_next = DISCARD;
          end
        end else if (mem_ack) begin
          fetch_pc_next = fetch_pc_inc;
          if (space_after) begin
            mem_addr_next = fetch_pc_inc;
          end else begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
          end
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          if (redirect || space_after) begin
            state_next    = REQ;
            mem_req_next  = 1'b1;
            mem_addr_next = target_pc;
          end else begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= '0;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

  assign mem_req  = mem_req_reg;
  assign mem_addr = mem_addr_reg;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_prefetch_unit
// Drives instr_prefetch_unit with a variable-latency memory model, random
// hold/redirect traffic and directed corner cases. The expected consumer
// stream is the rule "after reset or a redirect to P, the consumer sees
// P, P+1, P+2 ... (mod 256) with data 0x1000_0000+pc"; it is queued when the
// reset/redirect is issued and popped by an independent monitor.
// ---------------------------------------------------------------------------
module tb_instr_prefetch_unit;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              hold;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic [2:0]        count;

  always #5 clk = ~clk;

  instr_prefetch_unit #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .hold        (hold),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .count       (count)
  );

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_q[$];

  // memory model state
  bit                mem_busy = 0;
  int                wait_left = 0;
  logic [ADDR_W-1:0] cur_addr = '0;
  bit                rand_lat = 0;
  int                fixed_lat = 0;
  bit                req_started = 0;
  bit                exp_addr_pending = 0;
  logic [ADDR_W-1:0] exp_addr = '0;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'h1000_0000 + DATA_W'(a);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic restart_stream(input logic [ADDR_W-1:0] start);
    logic [ADDR_W-1:0] p;
    exp_q.delete();
    p = start;
    repeat (1024) begin
      exp_q.push_back(p);
      p = p + 8'd1;
    end
    exp_addr         = start;
    exp_addr_pending = 1;
  endtask

  // One clock of stimulus: at the falling edge run the memory model against
  // the request currently presented, then apply hold/redirect for the next
  // rising edge.
  task automatic step(input bit h, input bit r, input logic [ADDR_W-1:0] rpc);
    @(negedge clk);
    req_started = 0;
    if (reset && mem_req) begin
      if (!mem_busy) begin
        mem_busy    = 1;
        req_started = 1;
        cur_addr    = mem_addr;
        wait_left   = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
        if (exp_addr_pending) begin
          chk("first_req_addr", mem_addr, exp_addr);
          exp_addr_pending = 0;
        end
      end else begin
        chk("addr_stable", mem_addr, cur_addr);
      end
      if (wait_left == 0) begin
        mem_ack  = 1'b1;
        mem_data = mem_word(mem_addr);
        mem_busy = 0;
      end else begin
        mem_ack  = 1'b0;
        mem_data = $urandom;
        wait_left--;
      end
    end else begin
      mem_ack  = 1'b0;
      mem_data = $urandom;
      mem_busy = 0;
    end
    hold        = h;
    redirect    = r;
    redirect_pc = rpc;
    if (r) restart_stream(rpc);
  endtask

  // Monitor: every consumed head must be the next expected instruction.
  initial begin
    int starve;
    logic [ADDR_W-1:0] e;
    starve = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        checks++;
        if (count > 3'(DEPTH)) begin
          errors++;
          $display("FAIL count_range: got %0d required <= %0d", count, DEPTH);
        end
        if (instr_valid && !hold && !redirect) begin
          starve = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stream_empty: got pc %h with nothing expected", instr_pc);
          end else begin
            e = exp_q.pop_front();
            $display("pop pc=%02h instr=%08h expected pc=%02h", instr_pc, instr, e);
            chk("pop_pc", instr_pc, e);
            chk("pop_instr", instr, mem_word(e));
          end
        end else if (!hold && !redirect && !instr_valid) begin
          starve++;
          if (starve > 40) begin
            checks++;
            errors++;
            $display("FAIL starve: got no instruction for %0d cycles, required progress", starve);
            starve = 0;
          end
        end
      end else begin
        starve = 0;
      end
    end
  end

  initial begin
    logic [ADDR_W-1:0] held_pc;
    logic [ADDR_W-1:0] seen[4];
    logic [ADDR_W-1:0] w;
    int n;
    bit found;

    reset = 1'b0; redirect = 1'b0; redirect_pc = '0; hold = 1'b0;
    mem_ack = 1'b0; mem_data = '0;
    restart_stream(8'h00);
    repeat (2) step(0, 0, 8'h00);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_count", count, 0);

    // zero-latency memory, no stall
    reset = 1'b1;
    step(0, 0, 8'h00);
    chk("req_after_reset", mem_req, 1);
    chk("addr_after_reset", mem_addr, 0);
    step(0, 0, 8'h00);
    chk("first_valid", instr_valid, 1);
    chk("first_pc", instr_pc, 0);
    chk("first_instr", instr, mem_word(8'h00));
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 8'h00);
      chk("throughput_valid", instr_valid, 1);
    end

    // hold for 10 cycles: FIFO fills, request stops, head stays
    step(1, 0, 8'h00);
    held_pc = instr_pc;
    chk("hold_head_valid", instr_valid, 1);
    repeat (10) step(1, 0, 8'h00);
    chk("hold_count_full", count, 4);
    chk("hold_req_low", mem_req, 0);
    chk("hold_pc_held", instr_pc, held_pc);
    repeat (6) step(0, 0, 8'h00);

    // redirect coinciding with an ack and a pop
    step(0, 1, 8'h20);
    chk("rd_setup_req", mem_req, 1);
    chk("rd_setup_valid", instr_valid, 1);
    step(0, 0, 8'h00);
    chk("rd_count_zero", count, 0);
    chk("rd_valid_zero", instr_valid, 0);
    chk("rd_req", mem_req, 1);
    chk("rd_addr", mem_addr, 8'h20);
    repeat (5) step(0, 0, 8'h00);

    // address wrap
    step(0, 1, 8'hFE);
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      step(0, 0, 8'h00);
      if (instr_valid) begin
        seen[n] = instr_pc;
        n++;
      end
    end
    chk("wrap_seen", n, 4);
    for (int i = 0; i < n; i++) begin
      w = 8'hFE + 8'(i);
      chk("wrap_pc", seen[i], w);
    end

    // 3-cycle memory, redirect during the first wait cycle
    fixed_lat = 3;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 8'h00);
      if (req_started) begin
        found = 1;
        break;
      end
    end
    chk("lat3_req_seen", found, 1);
    step(0, 1, 8'h40);
    chk("lat3_req_pending", mem_req, 1);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 8'h00);
      if (instr_valid) begin
        found = 1;
        break;
      end
    end
    chk("discard_valid_seen", found, 1);
    chk("discard_first_pc", instr_pc, 8'h40);
    chk("discard_first_instr", instr, mem_word(8'h40));

    // asynchronous reset with three buffered entries and a request up
    fixed_lat = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 8'h00);
      if (count == 3'd3) break;
    end
    chk("pre_reset_count", count, 3);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_instr", instr, 0);
    chk("arst_pc", instr_pc, 0);
    chk("arst_req", mem_req, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_count", count, 0);
    mem_ack  = 1'b0;
    mem_busy = 0;
    restart_stream(8'h00);
    repeat (2) step(0, 0, 8'h00);
    reset = 1'b1;
    step(0, 0, 8'h00);
    chk("rearm_req", mem_req, 1);
    chk("rearm_addr", mem_addr, 0);

    // random traffic with random memory latency
    rand_lat = 1;
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 24) == 0, 8'($urandom));
    end
    repeat (10) step(0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
